// File: rtl/queue_dispatch_ctrl.sv
// Dispatch controller: pops the instruction queue into a 2-entry holding buffer
// and feeds a reservation station under a credit counter, with flush/drain handling.
module queue_dispatch_ctrl #(
   parameter  int D_WIDTH  = 32,
   parameter  int RS_DEPTH = 8,
   localparam int CW       = $clog2(RS_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               q_empty,
   output logic               q_r_en,
   input  logic [D_WIDTH-1:0] q_r_data,
   output logic               disp_valid,
   output logic [D_WIDTH-1:0] disp_data,
   input  logic               disp_ready,
   input  logic               rs_credit_ret,
   input  logic               flush,
   output logic [CW-1:0]      credits,
   output logic               credit_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   localparam logic [CW-1:0] CREDITS_MAX = CW'(RS_DEPTH);

   state_t               state, state_next;
   logic [1:0]           occ, occ_next, occ_after_fire;
   logic                 infl;
   logic [D_WIDTH-1:0]   buf_head, buf_tail, head_next, tail_next;
   logic [CW-1:0]        credits_next;
   logic                 credit_full, err_set;
   logic                 fire, capture;
   logic [2:0]           pending;

   assign disp_data = buf_head;

   // Handshake and pop decision. q_r_en sees disp_ready combinationally so a
   // full buffer that is draining this cycle can still accept a new pop.
   // NOTE: always_comb gives every output a default first so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      disp_valid = 1'b0;
      q_r_en     = 1'b0;
      disp_valid = !rst && (occ != 2'd0) && (credits != '0) && !flush && (state != DRAIN);
      fire       = disp_valid && disp_ready;
      capture    = infl && (state != DRAIN);
      pending    = {1'b0, occ} + {2'b00, infl} - {2'b00, fire};
      q_r_en     = !rst && !q_empty && !flush && (state != DRAIN) && (pending < 3'd2);
   end

   // Buffer occupancy and contents; the head shifts out on fire and the
   // returning read lands in the first free slot after that shift.
   always_comb begin
      occ_after_fire = occ - {1'b0, fire};
      occ_next       = occ;
      head_next      = buf_head;
      tail_next      = buf_tail;
      if (flush) begin
         occ_next = 2'd0;
      end else begin
         occ_next = occ_after_fire + {1'b0, capture};
         if (fire) head_next = buf_tail;
         if (capture) begin
            if (occ_after_fire == 2'd0) head_next = q_r_data;
            else                        tail_next = q_r_data;
         end
      end
   end

   // Credit counter: fire consumes, return refunds, both together cancel.
   always_comb begin
      credit_full  = (credits == CREDITS_MAX);
      err_set      = rs_credit_ret && !fire && credit_full;
      credits_next = credits;
      if (flush)
         credits_next = CREDITS_MAX;
      else if (fire && !rs_credit_ret)
         credits_next = credits - CW'(1);
      else if (rs_credit_ret && !fire && !credit_full)
         credits_next = credits + CW'(1);
   end

   // A flush with a read in flight spends one DRAIN cycle so that the
   // returning data is dropped instead of captured.
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = infl ? DRAIN : IDLE;
      end else begin
         case (state)
            IDLE:    if (q_r_en) state_next = ACTIVE;
            ACTIVE:  if ((occ_next == 2'd0) && !q_r_en) state_next = IDLE;
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         occ        <= 2'd0;
         infl       <= 1'b0;
         credits    <= CREDITS_MAX;
         credit_err <= 1'b0;
         buf_head   <= '0;
      end else begin
         state      <= state_next;
         occ        <= occ_next;
         infl       <= q_r_en;
         credits    <= credits_next;
         credit_err <= credit_err | err_set;
         buf_head   <= head_next;
      end
   end

   // NOTE: the tail slot is storage qualified by occ, so it carries no reset;
   // only the head is reset because it is visible on disp_data.
   always_ff @(posedge clk) begin
      buf_tail <= tail_next;
   end

endmodule
